// File: rtl/dma_cmd_scheduler.sv
// Round-robin arbiter sharing one AHB master command port among NREQ requesters.
// Gates each burst on FIFO space and supervises it with a completion timeout.
module dma_cmd_scheduler #(
   parameter int NREQ       = 4,
   parameter int FIFO_DEPTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NREQ-1:0]      i_req_valid,
   input  logic [NREQ*32-1:0]   i_req_addr,
   input  logic [NREQ*6-1:0]    i_req_len,
   output logic [NREQ-1:0]      o_grant,
   output logic [NREQ-1:0]      o_done,
   output logic                 o_err,
   output logic                 NewCommandOn,
   output logic [5:0]           o_RCC_BUFFER_LENGTH,
   output logic [15:0]          o_RCC_DMA_ADDR_HIGH,
   output logic [15:0]          o_RCC_DMA_ADDR_LOW,
   input  logic                 Master_Done,
   input  logic [5:0]           i_FIFO_data_count
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_BUSY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]       state_reg;
   logic [IDX_W-1:0] rr_ptr_reg;
   logic [IDX_W-1:0] owner_reg;
   logic [31:0]      addr_reg;
   logic [5:0]       len_reg;
   logic [TMR_W-1:0] timer_reg;
   logic [NREQ-1:0]  grant_reg;
   logic [NREQ-1:0]  done_reg;
   logic             err_reg;
   logic             cmd_strobe_reg;
   logic [5:0]       buf_len_reg;
   logic [15:0]      addr_hi_reg;
   logic [15:0]      addr_lo_reg;

   logic [31:0]      req_addr  [NREQ];
   logic [5:0]       req_len   [NREQ];
   logic [IDX_W-1:0] cand_idx  [NREQ];
   logic [NREQ-1:0]  cand_hit;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [6:0]       space;

   // cand_idx[gi] is the requester gi+1 places after the last owner
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_addr[gi] = i_req_addr[32*gi +: 32];
         assign req_len[gi]  = i_req_len[6*gi +: 6];
         assign cand_idx[gi] = IDX_W'((32'(rr_ptr_reg) + gi + 1) % NREQ);
         assign cand_hit[gi] = i_req_valid[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx[i];
         end
      end
   end

   // An over-full FIFO report reads as no room at all
   always_comb begin
      if ({1'b0, i_FIFO_data_count} > 7'(FIFO_DEPTH)) begin
         space = '0;
      end else begin
         space = 7'(FIFO_DEPTH) - {1'b0, i_FIFO_data_count};
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_reg      <= ST_IDLE;
         rr_ptr_reg     <= IDX_W'(NREQ - 1);
         owner_reg      <= '0;
         addr_reg       <= '0;
         len_reg        <= '0;
         timer_reg      <= '0;
         grant_reg      <= '0;
         done_reg       <= '0;
         err_reg        <= 1'b0;
         cmd_strobe_reg <= 1'b0;
         buf_len_reg    <= '0;
         addr_hi_reg    <= '0;
         addr_lo_reg    <= '0;
      end else begin
         cmd_strobe_reg <= 1'b0;
         done_reg       <= '0;
         err_reg        <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_found) begin
                  owner_reg <= pick_idx;
                  addr_reg  <= req_addr[pick_idx];
                  len_reg   <= req_len[pick_idx];
                  grant_reg <= NREQ'(1) << pick_idx;
                  state_reg <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (len_reg == 6'd0 || addr_reg[1:0] != 2'b00) begin
                  done_reg  <= grant_reg;
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
               end else if (space >= {1'b0, len_reg}) begin
                  cmd_strobe_reg <= 1'b1;
                  buf_len_reg    <= len_reg;
                  addr_hi_reg    <= addr_reg[31:16];
                  addr_lo_reg    <= addr_reg[15:0];
                  timer_reg      <= '0;
                  state_reg      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // timer_reg tracks cycles elapsed since the strobe
               timer_reg <= timer_reg + 1'b1;
               state_reg <= ST_BUSY;
            end
            ST_BUSY: begin
               timer_reg <= timer_reg + 1'b1;
               if (Master_Done) begin
                  done_reg  <= grant_reg;
                  state_reg <= ST_DONE;
               end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                  done_reg  <= grant_reg;
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               rr_ptr_reg <= owner_reg;
               grant_reg  <= '0;
               state_reg  <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign o_grant             = grant_reg;
   assign o_done              = done_reg;
   assign o_err               = err_reg;
   assign NewCommandOn        = cmd_strobe_reg;
   assign o_RCC_BUFFER_LENGTH = buf_len_reg;
   assign o_RCC_DMA_ADDR_HIGH = addr_hi_reg;
   assign o_RCC_DMA_ADDR_LOW  = addr_lo_reg;

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Directed plus randomized bench for dma_cmd_scheduler; expected owners, latencies
// and completion codes come from a transaction-level round-robin/timeout model.
module tb_dma_cmd_scheduler;

   localparam int NREQ       = 4;
   localparam int FIFO_DEPTH = 32;
   localparam int TIMEOUT    = 16;

   logic                HCLK;
   logic                HRESET;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*32-1:0]  addr_bus;
   logic [NREQ*6-1:0]   len_bus;
   logic [NREQ-1:0]     o_grant;
   logic [NREQ-1:0]     o_done;
   logic                o_err;
   logic                NewCommandOn;
   logic [5:0]          o_RCC_BUFFER_LENGTH;
   logic [15:0]         o_RCC_DMA_ADDR_HIGH;
   logic [15:0]         o_RCC_DMA_ADDR_LOW;
   logic                Master_Done;
   logic [5:0]          fifo_count;

   logic [31:0] req_addr [NREQ];
   logic [5:0]  req_len  [NREQ];
   int          rr_order [5] = '{0, 1, 2, 3, 0};
   int          rr_model;
   int          n_cmp;
   int          n_err;
   int          cyc;

   dma_cmd_scheduler #(
      .NREQ       (NREQ),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .HCLK                (HCLK),
      .HRESET              (HRESET),
      .i_req_valid         (req_valid),
      .i_req_addr          (addr_bus),
      .i_req_len           (len_bus),
      .o_grant             (o_grant),
      .o_done              (o_done),
      .o_err               (o_err),
      .NewCommandOn        (NewCommandOn),
      .o_RCC_BUFFER_LENGTH (o_RCC_BUFFER_LENGTH),
      .o_RCC_DMA_ADDR_HIGH (o_RCC_DMA_ADDR_HIGH),
      .o_RCC_DMA_ADDR_LOW  (o_RCC_DMA_ADDR_LOW),
      .Master_Done         (Master_Done),
      .i_FIFO_data_count   (fifo_count)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   always_comb begin
      addr_bus = '0;
      len_bus  = '0;
      for (int k = 0; k < NREQ; k++) begin
         addr_bus[32*k +: 32] = req_addr[k];
         len_bus[6*k +: 6]    = req_len[k];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] v);
      for (int i = 1; i <= NREQ; i++) begin
         if (v[(rr_model + i) % NREQ]) return (rr_model + i) % NREQ;
      end
      return 0;
   endfunction

   // Entered during an IDLE cycle with the request inputs already driven.
   // md_delay: cycles after the strobe at which Master_Done pulses, 0 = never.
   task automatic run_xfer(input int exp_owner, input int md_delay, input int drop_valid,
                           input int stall);
      logic [NREQ-1:0] exp_grant;
      logic [31:0]     a;
      logic [5:0]      l;
      int              space;
      int              quiet;
      int              spur;
      bit              bad;
      exp_grant            = '0;
      exp_grant[exp_owner] = 1'b1;
      a   = req_addr[exp_owner];
      l   = req_len[exp_owner];
      bad = (l == 6'd0) || (a[1:0] != 2'b00);
      tick();
      chk("grant", 32'(o_grant), 32'(exp_grant));
      if (bad) begin
         tick();
         chk("bad_done", 32'(o_done), 32'(exp_grant));
         chk("bad_err", 32'(o_err), 32'd1);
         chk("bad_no_cmd", 32'(NewCommandOn), 32'd0);
         $display("xfer owner=%0d addr=%08h len=%0d -> rejected", exp_owner, a, l);
      end else begin
         space = (int'(fifo_count) > FIFO_DEPTH) ? 0 : FIFO_DEPTH - int'(fifo_count);
         if (space < int'(l)) begin
            quiet = 0;
            for (int i = 0; i < stall; i++) begin
               tick();
               if (NewCommandOn !== 1'b0 || o_done !== '0) quiet++;
               Master_Done = (i == 0);
            end
            Master_Done = 1'b0;
            chk("stall_quiet", 32'(quiet), 32'd0);
            fifo_count = 6'(FIFO_DEPTH - int'(l));
         end
         tick();
         chk("cmd_strobe", 32'(NewCommandOn), 32'd1);
         chk("cmd_len", 32'(o_RCC_BUFFER_LENGTH), 32'(l));
         chk("cmd_high", 32'(o_RCC_DMA_ADDR_HIGH), 32'(a[31:16]));
         chk("cmd_low", 32'(o_RCC_DMA_ADDR_LOW), 32'(a[15:0]));
         if (drop_valid != 0) req_valid[exp_owner] = 1'b0;
         spur = 0;
         if (md_delay > 0) begin
            for (int i = 0; i < md_delay; i++) begin
               tick();
               if (o_done !== '0 || NewCommandOn !== 1'b0) spur++;
            end
            Master_Done = 1'b1;
            tick();
            Master_Done = 1'b0;
            chk("busy_quiet", 32'(spur), 32'd0);
            chk("ok_done", 32'(o_done), 32'(exp_grant));
            chk("ok_err", 32'(o_err), 32'd0);
         end else begin
            for (int i = 1; i < TIMEOUT; i++) begin
               tick();
               if (o_done !== '0 || NewCommandOn !== 1'b0) spur++;
            end
            tick();
            chk("busy_quiet", 32'(spur), 32'd0);
            chk("to_done", 32'(o_done), 32'(exp_grant));
            chk("to_err", 32'(o_err), 32'd1);
         end
         $display("xfer owner=%0d addr=%08h len=%0d md_delay=%0d -> err=%0b",
                  exp_owner, a, l, md_delay, o_err);
      end
      tick();
      chk("idle_grant", 32'(o_grant), 32'd0);
      chk("idle_done", 32'(o_done | NREQ'(o_err)), 32'd0);
      rr_model = exp_owner;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      cyc         = 0;
      HRESET      = 1'b1;
      req_valid   = '0;
      Master_Done = 1'b0;
      fifo_count  = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_addr[k] = '0;
         req_len[k]  = '0;
      end
      repeat (2) tick();
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_cmd", 32'(NewCommandOn), 32'd0);
      chk("rst_len", 32'(o_RCC_BUFFER_LENGTH), 32'd0);
      chk("rst_addr", {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, 32'd0);
      HRESET   = 1'b0;
      rr_model = NREQ - 1;
      tick();

      // all requesters held: strict rotation
      for (int k = 0; k < NREQ; k++) begin
         req_addr[k] = 32'h0000_2000 + 32'(k * 256);
         req_len[k]  = 6'd4;
      end
      req_valid = '1;
      for (int n = 0; n < 5; n++) run_xfer(rr_order[n], 3, 0, 0);

      // single request, Master_Done 8 cycles after the strobe
      req_valid   = 4'b0001;
      req_addr[0] = 32'h0000_1000;
      req_len[0]  = 6'd8;
      fifo_count  = 6'd0;
      run_xfer(0, 8, 0, 0);

      // backpressure: 12 words free for a 16-word burst
      req_valid   = 4'b0010;
      req_addr[1] = 32'h0000_3000;
      req_len[1]  = 6'd16;
      fifo_count  = 6'd20;
      run_xfer(1, 5, 0, 4);

      // zero length and misaligned address
      fifo_count  = 6'd0;
      req_valid   = 4'b0100;
      req_len[2]  = 6'd0;
      run_xfer(2, 3, 0, 0);
      req_valid   = 4'b1000;
      req_addr[3] = 32'h0000_1002;
      req_len[3]  = 6'd4;
      run_xfer(3, 3, 0, 0);

      // timeout, then completion on the last allowed cycle with the request dropped
      req_valid = 4'b0001;
      req_len[0] = 6'd4;
      run_xfer(0, 0, 0, 0);
      req_valid = 4'b0010;
      req_len[1] = 6'd8;
      run_xfer(1, TIMEOUT - 1, 1, 0);

      // Master_Done with nobody granted
      req_valid   = '0;
      Master_Done = 1'b1;
      tick();
      Master_Done = 1'b0;
      tick();
      chk("idle_md_done", 32'(o_done), 32'd0);
      chk("idle_md_grant", 32'(o_grant), 32'd0);

      // reset while requester 2 is busy
      req_addr[0] = 32'h0000_5000;
      req_len[0]  = 6'd4;
      req_addr[2] = 32'h0000_4000;
      req_len[2]  = 6'd8;
      req_valid   = 4'b0101;
      tick();
      chk("pre_rst_grant", 32'(o_grant), 32'(4'b0100));
      tick();
      chk("pre_rst_cmd", 32'(NewCommandOn), 32'd1);
      repeat (2) tick();
      #2;
      HRESET = 1'b1;
      #1;
      chk("async_grant", 32'(o_grant), 32'd0);
      chk("async_done", 32'(o_done), 32'd0);
      chk("async_cmd", 32'(NewCommandOn), 32'd0);
      tick();
      HRESET   = 1'b0;
      rr_model = NREQ - 1;
      $display("reset applied during BUSY of requester 2");
      run_xfer(model_pick(req_valid), 6, 0, 0);

      // randomized traffic
      for (int it = 0; it < 14; it++) begin
         int md;
         for (int k = 0; k < NREQ; k++) begin
            req_addr[k] = $urandom;
            if ($urandom_range(0, 3) != 0) req_addr[k][1:0] = 2'b00;
            req_len[k] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, FIFO_DEPTH));
         end
         req_valid  = NREQ'($urandom_range(1, (2 ** NREQ) - 1));
         fifo_count = 6'($urandom_range(0, 63));
         md = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT - 1));
         run_xfer(model_pick(req_valid), md, int'($urandom_range(0, 1)),
                  int'($urandom_range(1, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dma_cmd_scheduler.md
Name: dma_cmd_scheduler

Overview:
- Shares the single AHB master command interface (NewCommandOn / RCC_BUFFER_LENGTH / RCC_DMA_ADDR_HIGH/LOW / Master_Done) among NREQ requesters using round-robin arbitration.
- Issues a burst command only when the master-side FIFO has room for the whole burst.
- Supervises each transfer with a timeout and returns a per-requester done/error pulse.
- Sits between the requesters and ahb3lite_master in the HCLK domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 32, word capacity of the master-side async FIFO.
- TIMEOUT, 1024, HCLK cycles allowed from command issue to Master_Done.

Ports:
- HCLK  in  1  the only clock.
- HRESET  in  1  asynchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester command request, level; held until the matching o_done.
- i_req_addr  in  NREQ*32  per-requester byte start address; slice k = [32k+31:32k].
- i_req_len  in  NREQ*6  per-requester burst length in words; slice k = [6k+5:6k].
- o_grant  out  NREQ  one-hot; identifies the requester currently owned, 0 when IDLE.
- o_done  out  NREQ  one-cycle completion pulse to the owner.
- o_err  out  1  qualifies o_done: 1 = error completion.
- NewCommandOn  out  1  one-cycle command strobe to the master.
- o_RCC_BUFFER_LENGTH  out  6  latched burst length.
- o_RCC_DMA_ADDR_HIGH  out  16  latched address [31:16].
- o_RCC_DMA_ADDR_LOW  out  16  latched address [15:0].
- Master_Done  in  1  master completion pulse.
- i_FIFO_data_count  in  6  current write-side FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, state = IDLE, rr_ptr = NREQ-1 (so requester 0 wins first), timer = 0.
- All outputs are registered.
- IDLE:
  - If any i_req_valid is set, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - Latch that requester's addr and len, set o_grant, go to CHECK.
- CHECK:
  - If len == 0 or addr[1:0] != 0: go to DONE with err = 1. No command is issued.
  - Else if (FIFO_DEPTH - i_FIFO_data_count) >= len: go to ISSUE.
  - Else stay in CHECK indefinitely. There is no starvation timeout here.
- ISSUE:
  - Assert NewCommandOn for exactly one cycle.
  - Length and address outputs are valid in this cycle and hold until the next ISSUE.
  - Clear the timer and go to BUSY.
- BUSY:
  - Timer increments each cycle.
  - Master_Done = 1: go to DONE with err = 0.
  - Else if timer == TIMEOUT-1: go to DONE with err = 1.
  - Master_Done in the same cycle as the timeout counts as success.
- DONE:
  - o_done[owner] = 1 and o_err valid for one cycle.
  - rr_ptr <= owner index; o_grant cleared; go to IDLE.
- Latency:
  - i_req_valid seen in IDLE at cycle 0 gives o_grant at cycle 1, and NewCommandOn at cycle 2 if space is sufficient.
  - Master_Done at cycle n gives o_done at cycle n+1.
  - The next grant comes at the earliest one cycle after o_done (one IDLE cycle between transfers).
- Master_Done outside BUSY is ignored.
- A requester dropping i_req_valid after grant does not abort the transfer; it still completes and o_done is still pulsed.
- Requests that arrive while not IDLE wait; there is no queueing beyond the level-held valid.
- Space arithmetic: FIFO_DEPTH - i_FIFO_data_count is computed at 7 bits unsigned. An occupancy above FIFO_DEPTH is treated as zero space.
- Reset mid-transfer:
  - All state clears immediately, with no o_done pulse.
  - The interrupted owner must re-request.

Test Plan:
- Single request: req0 valid, addr=0x0000_1000, len=8, count=0 -> o_grant=0001 at c1; NewCommandOn at c2 with HIGH=0x0000, LOW=0x1000, LEN=8; Master_Done at c10 -> o_done=0001, o_err=0 at c11.
- Round-robin: req0..req3 all held valid, each Master_Done after 3 cycles -> grant order 0,1,2,3,0; none skipped or repeated.
- FIFO backpressure: len=16, count=20 (space 12) -> stays in CHECK with no NewCommandOn; count drops to 16 -> NewCommandOn issued the following cycle.
- Error cases:
  - len=0 -> o_done with o_err=1 and no NewCommandOn.
  - addr=0x1002 -> same result.
  - No Master_Done with TIMEOUT=16 -> o_err=1 exactly 16 cycles after NewCommandOn.
- Boundary: Master_Done on the timeout cycle -> o_err=0. Master_Done pulsed in IDLE -> no effect.
- HRESET asserted in BUSY -> o_grant, o_done, and NewCommandOn go to 0 immediately; after release, requester 0 wins first.
